// File: rtl/rf_drv_pkg.sv
// Shared types and helpers for the register-file command driver.
package rf_drv_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned SAT_W    = 64;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_WRITE    = 2'd1,
    OP_READ     = 2'd2,
    OP_WRITE_RB = 2'd3
  } drv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_RESP
  } drv_state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/rf_drv_sat_cnt.sv
// Saturating event counter (CNT_W <= 64); holds at all-ones.
module rf_drv_sat_cnt
  import rf_drv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [SAT_W-1:0] MAX_VAL = SAT_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = CNT_W'(sat_inc(SAT_W'(cnt_q), MAX_VAL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rf_cmd_driver.sv
// Command initiator for the hot/cold register file: one response per command.
// Optional readback compare on WRITE_RB is enabled by RF_DRV_RB_CHECK_EN.
module rf_cmd_driver
  import rf_drv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_waddr,
  input  logic [AW-1:0]    cmd_raddr_1,
  input  logic [AW-1:0]    cmd_raddr_2,
  input  logic [XLEN-1:0]  cmd_wdata,
  input  logic             cmd_cold,
  input  logic             cmd_is16,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rdata_1,
  output logic [XLEN-1:0]  rsp_rdata_2,
  output logic             rsp_err,
  output logic             rsp_mismatch,
  output logic [AW-1:0]    rf_raddr_1,
  output logic [AW-1:0]    rf_raddr_2,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             rf_regwrite,
  output logic             rf_is16,
  output logic             rf_cold_en,
  input  logic [XLEN-1:0]  rf_rdata_1,
  input  logic [XLEN-1:0]  rf_rdata_2,
  input  logic             rf_cold_en_err,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  drv_state_e      state_q, state_d;
  drv_op_e         op_q, op_d;
  logic [AW-1:0]   waddr_q, waddr_d, raddr1_q, raddr1_d, raddr2_q, raddr2_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            cold_q, cold_d, is16_q, is16_d;
  logic            cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic            err_q, err_d;
  logic [AW-1:0]   rf_raddr_1_q, rf_raddr_1_d, rf_raddr_2_q, rf_raddr_2_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            rf_regwrite_q, rf_regwrite_d, rf_is16_q, rf_is16_d;
  logic            rf_cold_en_q, rf_cold_en_d;
  logic            accept_c, sample_c, fire_c;

  // Next state, command latch, data/error capture
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    waddr_d  = waddr_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    wdata_d  = wdata_q;
    cold_d   = cold_q;
    is16_d   = is16_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    err_d    = err_q;
    accept_c = 1'b0;
    sample_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept_c = 1'b1;
          op_d     = drv_op_e'(cmd_op);
          waddr_d  = cmd_waddr;
          raddr1_d = cmd_raddr_1;
          raddr2_d = cmd_raddr_2;
          wdata_d  = cmd_wdata;
          cold_d   = cmd_cold;
          is16_d   = cmd_is16;
          rdata1_d = '0;
          rdata2_d = '0;
          err_d    = 1'b0;
          case (drv_op_e'(cmd_op))
            OP_WRITE, OP_WRITE_RB: state_d = ST_WR;
            OP_READ:               state_d = ST_RD;
            default:               state_d = ST_RESP;
          endcase
        end
      end
      ST_WR: begin
        err_d   = err_q | rf_cold_en_err;
        state_d = (op_q == OP_WRITE_RB) ? ST_RD : ST_RESP;
      end
      ST_RD: begin
        err_d = err_q | rf_cold_en_err;
        if (RD_LAT == 0) begin
          sample_c = 1'b1;
          state_d  = ST_RESP;
        end else begin
          state_d  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        err_d    = err_q | rf_cold_en_err;
        sample_c = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (sample_c) begin
      rdata1_d = rf_rdata_1;
      rdata2_d = rf_rdata_2;
    end
  end

  // Register-file drive and handshake outputs, registered against the next state
  always_comb begin
    rf_regwrite_d = 1'b0;
    rf_waddr_d    = '0;
    rf_wdata_d    = '0;
    rf_raddr_1_d  = '0;
    rf_raddr_2_d  = '0;
    rf_is16_d     = 1'b0;
    rf_cold_en_d  = 1'b0;
    case (state_d)
      ST_WR: begin
        rf_regwrite_d = 1'b1;
        rf_waddr_d    = waddr_d;
        rf_wdata_d    = wdata_d;
        rf_is16_d     = is16_d;
        rf_cold_en_d  = cold_d;
      end
      ST_RD, ST_RD_WAIT: begin
        rf_raddr_1_d = (op_d == OP_WRITE_RB) ? waddr_d : raddr1_d;
        rf_raddr_2_d = (op_d == OP_WRITE_RB) ? waddr_d : raddr2_d;
        rf_is16_d    = is16_d;
        rf_cold_en_d = cold_d;
      end
      default: ;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NOP;
      waddr_q       <= '0;
      raddr1_q      <= '0;
      raddr2_q      <= '0;
      wdata_q       <= '0;
      cold_q        <= 1'b0;
      is16_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rdata1_q      <= '0;
      rdata2_q      <= '0;
      err_q         <= 1'b0;
      rf_raddr_1_q  <= '0;
      rf_raddr_2_q  <= '0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rf_regwrite_q <= 1'b0;
      rf_is16_q     <= 1'b0;
      rf_cold_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      waddr_q       <= waddr_d;
      raddr1_q      <= raddr1_d;
      raddr2_q      <= raddr2_d;
      wdata_q       <= wdata_d;
      cold_q        <= cold_d;
      is16_q        <= is16_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      err_q         <= err_d;
      rf_raddr_1_q  <= rf_raddr_1_d;
      rf_raddr_2_q  <= rf_raddr_2_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_regwrite_q <= rf_regwrite_d;
      rf_is16_q     <= rf_is16_d;
      rf_cold_en_q  <= rf_cold_en_d;
    end
  end

`ifdef RF_DRV_RB_CHECK_EN
  // Readback compare; a blocked or x0 write is expected to read back as zero
  logic            mismatch_q, mismatch_d;
  logic [XLEN-1:0] rb_exp_c;

  always_comb begin
    mismatch_d = mismatch_q;
    rb_exp_c   = (waddr_q == '0 || err_d) ? '0 : wdata_q;
    if (accept_c)      mismatch_d = 1'b0;
    else if (sample_c) mismatch_d = (op_q == OP_WRITE_RB) && (rf_rdata_1 != rb_exp_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end

  assign rsp_mismatch = mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign fire_c = rsp_valid_q && rsp_ready;

  rf_drv_sat_cnt #(.CNT_W(CNT_W)) u_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fire_c),
    .cnt   (txn_cnt)
  );

  rf_drv_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fire_c && err_q),
    .cnt   (err_cnt)
  );

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata_1 = rdata1_q;
  assign rsp_rdata_2 = rdata2_q;
  assign rsp_err     = err_q;
  assign rf_raddr_1  = rf_raddr_1_q;
  assign rf_raddr_2  = rf_raddr_2_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_regwrite = rf_regwrite_q;
  assign rf_is16     = rf_is16_q;
  assign rf_cold_en  = rf_cold_en_q;

endmodule

// File: tb/tb_rf_cmd_driver.sv
// Directed bench for rf_cmd_driver with a small hot/cold register-file model (x4 is cold).
// Counter width is narrowed so saturation is reachable in a short run.
module tb_rf_cmd_driver;

  localparam int unsigned CNT_W = 10;
  localparam logic [63:0] V1 = 64'h123456789ABCDEF0;
  localparam logic [63:0] V2 = 64'hDEADBEEFDEADBEEF;
`ifdef RF_DRV_RB_CHECK_EN
  localparam bit RB_CHK = 1'b1;
`else
  localparam bit RB_CHK = 1'b0;
`endif

  logic clk, rst_n;
  logic cmd_valid, cmd_ready, cmd_cold, cmd_is16;
  logic [1:0] cmd_op;
  logic [4:0] cmd_waddr, cmd_raddr_1, cmd_raddr_2;
  logic [63:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err, rsp_mismatch;
  logic [63:0] rsp_rdata_1, rsp_rdata_2;
  logic [4:0] rf_raddr_1, rf_raddr_2, rf_waddr;
  logic [63:0] rf_wdata, rf_rdata_1, rf_rdata_2;
  logic rf_regwrite, rf_is16, rf_cold_en, rf_cold_en_err;
  logic [CNT_W-1:0] txn_cnt, err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  rf_cmd_driver #(.XLEN(64), .AW(5), .RD_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_waddr(cmd_waddr), .cmd_raddr_1(cmd_raddr_1), .cmd_raddr_2(cmd_raddr_2),
    .cmd_wdata(cmd_wdata), .cmd_cold(cmd_cold), .cmd_is16(cmd_is16),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata_1(rsp_rdata_1), .rsp_rdata_2(rsp_rdata_2),
    .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch),
    .rf_raddr_1(rf_raddr_1), .rf_raddr_2(rf_raddr_2), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_regwrite(rf_regwrite), .rf_is16(rf_is16),
    .rf_cold_en(rf_cold_en), .rf_rdata_1(rf_rdata_1), .rf_rdata_2(rf_rdata_2),
    .rf_cold_en_err(rf_cold_en_err), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: 1-cycle read, x0 reads zero, x4 needs cold authorisation
  logic [63:0] regs [32];
  logic [63:0] rd1_q, rd2_q;
  logic        corrupt;

  function automatic logic [63:0] rd_val(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : regs[a];
  endfunction

  assign rf_cold_en_err = rf_regwrite && (rf_waddr == 5'd4) && !rf_cold_en;
  assign rf_rdata_1 = rd1_q;
  assign rf_rdata_2 = rd2_q;

  always @(posedge clk) begin
    if (rf_regwrite && rf_waddr != 5'd0 && !rf_cold_en_err) regs[rf_waddr] <= rf_wdata;
    rd1_q <= rd_val(rf_raddr_1) ^ ((corrupt && rf_raddr_1 == 5'd6) ? 64'd1 : 64'd0);
    rd2_q <= rd_val(rf_raddr_2);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] wa, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [63:0] wd, input logic cold,
                      input logic is16);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
    chk("cmd_ready_seen", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_waddr = wa; cmd_raddr_1 = r1; cmd_raddr_2 = r2;
    cmd_wdata = wd; cmd_cold = cold; cmd_is16 = is16;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output int wr_cyc, output logic [4:0] s_wa,
                         output logic [63:0] s_wd, output logic s_is16);
    lat = 0; wr_cyc = 0; s_wa = '0; s_wd = '0; s_is16 = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (rf_regwrite) begin wr_cyc++; s_wa = rf_waddr; s_wd = rf_wdata; s_is16 = rf_is16; end
    end while (!rsp_valid && lat < 20);
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic pop();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  int lat, wr_cyc, fires, cyc;
  logic [4:0] s_wa;
  logic [63:0] s_wd;
  logic s_is16;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    rst_n = 1'b0; corrupt = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_waddr = '0; cmd_raddr_1 = '0; cmd_raddr_2 = '0;
    cmd_wdata = '0; cmd_cold = 1'b0; cmd_is16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_regwrite", 64'(rf_regwrite), 64'd0);
    chk("rst_txn", 64'(txn_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // WRITE x5 (16-bit mode)
    send(2'd1, 5'd5, 5'd0, 5'd0, V1, 1'b0, 1'b1);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("wr_lat", 64'(lat), 64'd2);
    chk("wr_cycles", 64'(wr_cyc), 64'd1);
    chk("wr_addr", 64'(s_wa), 64'd5);
    chk("wr_data", s_wd, V1);
    chk("wr_is16", 64'(s_is16), 64'd1);
    chk("wr_rdata1", rsp_rdata_1, 64'd0);
    chk("wr_err", 64'(rsp_err), 64'd0);
    pop();

    // READ x5 on both ports
    send(2'd2, 5'd0, 5'd5, 5'd5, 64'd0, 1'b0, 1'b0);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_wr_cycles", 64'(wr_cyc), 64'd0);
    chk("rd_rdata1", rsp_rdata_1, V1);
    chk("rd_rdata2", rsp_rdata_2, V1);
    chk("rd_err", 64'(rsp_err), 64'd0);
    pop();
    chk("rd_txn", 64'(txn_cnt), 64'd2);

    // WRITE_RB to cold x4 without authorisation
    send(2'd3, 5'd4, 5'd0, 5'd0, V1, 1'b0, 1'b0);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("cold_lat", 64'(lat), 64'd4);
    chk("cold_err", 64'(rsp_err), 64'd1);
    chk("cold_rdata1", rsp_rdata_1, 64'd0);
    chk("cold_mismatch", 64'(rsp_mismatch), 64'd0);
    pop();
    chk("cold_err_cnt", 64'(err_cnt), 64'd1);
    chk("cold_txn", 64'(txn_cnt), 64'd3);

    // WRITE_RB to x0
    send(2'd3, 5'd0, 5'd0, 5'd0, V2, 1'b0, 1'b0);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("x0_rdata1", rsp_rdata_1, 64'd0);
    chk("x0_rdata2", rsp_rdata_2, 64'd0);
    chk("x0_mismatch", 64'(rsp_mismatch), 64'd0);
    chk("x0_err", 64'(rsp_err), 64'd0);
    pop();

    // WRITE_RB to x6 with port-1 corruption, response held for 5 cycles
    corrupt = 1'b1;
    send(2'd3, 5'd6, 5'd0, 5'd0, V2, 1'b0, 1'b0);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("x6_rdata1", rsp_rdata_1, 64'hDEADBEEFDEADBEEE);
    chk("x6_rdata2", rsp_rdata_2, V2);
    chk("x6_mismatch", 64'(rsp_mismatch), 64'(RB_CHK));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_ready", 64'(cmd_ready), 64'd0);
      chk("hold_rdata1", rsp_rdata_1, 64'hDEADBEEFDEADBEEE);
      chk("hold_txn", 64'(txn_cnt), 64'd4);
    end
    pop();
    chk("hold_txn_after", 64'(txn_cnt), 64'd5);
    chk("hold_err_after", 64'(err_cnt), 64'd1);
    corrupt = 1'b0;

    // Reset during RD_WAIT
    send(2'd2, 5'd0, 5'd5, 5'd6, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rdwait_raddr", 64'(rf_raddr_1), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regwrite", 64'(rf_regwrite), 64'd0);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_raddr", 64'(rf_raddr_1), 64'd0);
    chk("mid_rst_txn", 64'(txn_cnt), 64'd0);
    chk("mid_rst_err", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd2, 5'd0, 5'd5, 5'd6, 64'd0, 1'b0, 1'b0);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_rdata1", rsp_rdata_1, V1);
    chk("post_rst_rdata2", rsp_rdata_2, V2);
    pop();
    chk("post_rst_txn", 64'(txn_cnt), 64'd1);

    // NOP goes straight to a zero response
    send(2'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0);
    collect(lat, wr_cyc, s_wa, s_wd, s_is16);
    chk("nop_lat", 64'(lat), 64'd1);
    chk("nop_rdata1", rsp_rdata_1, 64'd0);
    chk("nop_err", 64'(rsp_err), 64'd0);
    pop();
    chk("nop_txn", 64'(txn_cnt), 64'd2);

    // Streamed NOPs past the counter ceiling
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; rsp_ready = 1'b1;
    fires = 0; cyc = 0;
    while (fires < 1025 && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (rsp_valid && rsp_ready) begin
        fires++;
        if (fires == 1025) cmd_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("sat_fires", 64'(fires), 64'd1025);
    chk("sat_txn", 64'(txn_cnt), 64'h3FF);
    chk("sat_err", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/rf_cmd_driver.md
Name: rf_cmd_driver

Overview:
- Initiator for the 64-bit hot/cold register file: accepts register-access commands over a valid/ready interface and drives the register file's write and read ports.
- Captures read data and the cold-enable error, then returns one response per command.
- Sits between a test/debug controller (or scrubber) and the register file; the register file is its responder.

Parameters:
- XLEN, 64, data width of register file ports.
- AW, 5, register address width (32 registers; x0 hardwired zero).
- RD_LAT, 1, cycles from read address presented to rdata valid (legal: 0 or 1).
- CNT_W, 16, width of transaction/error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept command.
- cmd_op  in  2  0=NOP, 1=WRITE, 2=READ, 3=WRITE_RB (write then read back).
- cmd_waddr  in  AW  write address.
- cmd_raddr_1  in  AW  read address port 1.
- cmd_raddr_2  in  AW  read address port 2.
- cmd_wdata  in  XLEN  write data.
- cmd_cold  in  1  cold-register authorisation for this command.
- cmd_is16  in  1  16-bit instruction mode for this command.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata_1  out  XLEN  captured port-1 data (0 for WRITE/NOP).
- rsp_rdata_2  out  XLEN  captured port-2 data (0 for WRITE/NOP).
- rsp_err  out  1  cold_en_err seen during command.
- rsp_mismatch  out  1  readback differed from written data (see Optional Feature).
- rf_raddr_1, rf_raddr_2, rf_waddr  out  AW  to register file.
- rf_wdata  out  XLEN  to register file.
- rf_regwrite, rf_is16, rf_cold_en  out  1  to register file.
- rf_rdata_1, rf_rdata_2  in  XLEN  from register file.
- rf_cold_en_err  in  1  from register file.
- txn_cnt  out  CNT_W  completed responses.
- err_cnt  out  CNT_W  responses with rsp_err=1.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; counters 0. cmd_ready rises the first cycle after rst_n deasserts.
- FSM states: IDLE, WR, RD, RD_WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields. Next state: op WRITE/WRITE_RB→WR; READ→RD; NOP→RESP.
- WR: exactly one cycle. rf_regwrite=1; rf_waddr/rf_wdata/rf_cold_en/rf_is16 from latched fields. Next state: WRITE→RESP; WRITE_RB→RD with rf_raddr_1=rf_raddr_2=waddr.
- RD: drive read addresses; rf_regwrite=0. If RD_LAT=0, sample rf_rdata_* this cycle and go to RESP; otherwise go to RD_WAIT.
- RD_WAIT: one cycle, sample rf_rdata_*, then RESP.
- Error capture: rsp_err = OR of rf_cold_en_err over every cycle from WR/RD entry up to and including the sample cycle.
- RESP: rsp_valid=1, fields stable until rsp_ready. When rsp_valid&&rsp_ready: txn_cnt++ and err_cnt+=rsp_err (both saturate at all-ones, no wrap); next state IDLE.
- Latency, READ with RD_LAT=1: accept→rsp_valid is 3 cycles. Back-to-back throughput is one command per 4 cycles minimum.
- rf_* outputs: registered; return to 0 except in WR/RD/RD_WAIT. Addresses hold through RD_WAIT.
- Reset mid-operation: FSM returns to IDLE immediately; rf_regwrite drops asynchronously; the in-flight response is discarded.
- Write to x0: driven normally; readback is expected to be 0.

Optional Feature:
- Macro RF_DRV_RB_CHECK_EN.
- Defined: on WRITE_RB, rsp_mismatch=1 if rf_rdata_1 != latched wdata. Exception: expected value is 0 when waddr=0 or when rsp_err=1 (write blocked).
- Undefined: rsp_mismatch tied 0; WRITE_RB is still performed and returns data.

Decomposition:
- Package rf_drv_pkg: op enum (NOP/WRITE/READ/WRITE_RB), FSM state enum, XLEN/AW defaults, saturating-increment function.
- Sub-module rf_drv_sat_cnt (saturating counter, CNT_W), instantiated twice.

Test Plan:
- WRITE x5=0x123456789ABCDEF0, then READ r1=r2=x5 → rsp_rdata_1=rsp_rdata_2=0x123456789ABCDEF0, rsp_err=0, txn_cnt=2.
- WRITE_RB to cold x4 with cmd_cold=0 (RD_LAT=1), register file asserts cold_en_err → rsp_err=1, err_cnt=1, rsp_mismatch=0 (with macro defined).
- WRITE_RB x0=0xDEADBEEFDEADBEEF → rsp_rdata_1=0, rsp_mismatch=0; the same command to x6 with the model corrupting bit 0 → rsp_mismatch=1.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp fields stable, cmd_ready=0, no counter change; release → single increment.
- Assert rst_n=0 during RD_WAIT → rf_regwrite=0, rsp_valid=0, counters 0; the next READ completes normally.
- Issue 0xFFFF successful commands plus 2 more → txn_cnt saturates at 0xFFFF.
